// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, reset level, x0 address and wrap-aware tag age compare.
package wb_port_arbiter_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int TAG_W  = 4;
   localparam logic RST_LVL = 1'b0;
   localparam logic [ADDR_W-1:0] X0_ADDR = '0;

   // a is older than b when b is ahead of a by less than half the tag space
   function automatic logic tag_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
      logic [TAG_W-1:0] d;
      d = b - a;
      return (d != '0) && !d[TAG_W-1];
   endfunction
endpackage

// File: rtl/wb_age_cmp.sv
// wb_age_cmp: combinational wrap-around sequence tag comparator.
module wb_age_cmp #(
   parameter int TAG_W = wb_port_arbiter_pkg::TAG_W
) (
   input  logic [TAG_W-1:0] a_tag_i,
   input  logic [TAG_W-1:0] b_tag_i,
   output logic             a_older_o
);
   logic [TAG_W-1:0] diff;
   assign diff      = b_tag_i - a_tag_i;
   assign a_older_o = (diff != '0) && !diff[TAG_W-1];
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates ALU and load writebacks onto the single regfile write port.
module wb_port_arbiter #(
   parameter int DATA_W     = wb_port_arbiter_pkg::DATA_W,
   parameter int ADDR_W     = wb_port_arbiter_pkg::ADDR_W,
   parameter int TAG_W      = wb_port_arbiter_pkg::TAG_W,
   parameter int STARVE_LIM = 3,
   parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush_in,
   input  logic              a_valid_in,
   input  logic [ADDR_W-1:0] a_addr_in,
   input  logic [DATA_W-1:0] a_data_in,
   input  logic [TAG_W-1:0]  a_tag_in,
   output logic              a_ready_out,
   input  logic              b_valid_in,
   input  logic [ADDR_W-1:0] b_addr_in,
   input  logic [DATA_W-1:0] b_data_in,
   input  logic [TAG_W-1:0]  b_tag_in,
   output logic              b_ready_out,
   output logic              wb_we_out,
   output logic [ADDR_W-1:0] wb_addr_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [CNT_W-1:0]  starve_cnt_out
);
   import wb_port_arbiter_pkg::*;

   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   logic              a_older, same_reg, live, grant_a, grant_b, win_we;
   logic [ADDR_W-1:0] win_addr, wb_addr_q;
   logic [DATA_W-1:0] win_data, wb_data_q;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              wb_we_q;

   wb_age_cmp #(.TAG_W(TAG_W)) u_age_cmp (
      .a_tag_i   (a_tag_in),
      .b_tag_i   (b_tag_in),
      .a_older_o (a_older)
   );

   always_comb begin
      live     = (rst_in != RST_LVL) && !flush_in;
      same_reg = (a_addr_in == b_addr_in) && (a_addr_in != '0);
      grant_a  = live && a_valid_in &&
                 (!b_valid_in || (same_reg ? a_older : (starve_q == LIM)));
      grant_b  = live && b_valid_in && !grant_a;
      win_addr = grant_a ? a_addr_in : b_addr_in;
      win_data = grant_a ? a_data_in : b_data_in;
      win_we   = (grant_a || grant_b) && (win_addr != '0);
      starve_d = (flush_in || !a_valid_in || grant_a) ? '0 :
                 (starve_q == LIM) ? LIM : starve_q + 1'b1;
   end

   // x0 writes are accepted but leave the address/data register untouched
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (rst_in == RST_LVL) begin
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         starve_q  <= '0;
      end else begin
         wb_we_q  <= win_we;
         starve_q <= starve_d;
         if (win_we) begin
            wb_addr_q <= win_addr;
            wb_data_q <= win_data;
         end
      end
   end

   assign a_ready_out    = grant_a;
   assign b_ready_out    = grant_b;
   assign wb_we_out      = wb_we_q;
   assign wb_addr_out    = wb_addr_q;
   assign wb_data_out    = wb_data_q;
   assign starve_cnt_out = starve_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_wb_port_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        a_v = 1'b0, b_v = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic [3:0]  a_tag = '0, b_tag = '0;
   logic        a_rdy, b_rdy, we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  cnt;

   int checks = 0, errors = 0;
   int m_cnt = 0;
   logic m_we = 1'b0;
   logic [4:0] m_addr = '0;
   logic [31:0] m_data = '0;

   always #5 clk = ~clk;

   wb_port_arbiter dut (
      .clk_in(clk), .rst_in(rst_n), .flush_in(flush),
      .a_valid_in(a_v), .a_addr_in(a_addr), .a_data_in(a_data), .a_tag_in(a_tag), .a_ready_out(a_rdy),
      .b_valid_in(b_v), .b_addr_in(b_addr), .b_data_in(b_data), .b_tag_in(b_tag), .b_ready_out(b_rdy),
      .wb_we_out(we), .wb_addr_out(wb_addr), .wb_data_out(wb_data), .starve_cnt_out(cnt)
   );

   // 0 = no grant, 1 = A, 2 = B, straight from the priority rules
   function automatic int exp_grant();
      int d;
      if (!rst_n || flush || (!a_v && !b_v)) return 0;
      if (a_v && !b_v) return 1;
      if (!a_v) return 2;
      if (a_addr == b_addr && a_addr != 0) begin
         d = (int'(b_tag) - int'(a_tag) + 16) % 16;
         return (d >= 1 && d <= 7) ? 1 : 2;
      end
      return (m_cnt == 3) ? 1 : 2;
   endfunction

   task automatic tick();
      int g;
      g = exp_grant();
      @(posedge clk);
      m_cnt = (flush || !a_v || g == 1) ? 0 : (m_cnt < 3 ? m_cnt + 1 : 3);
      m_we  = (g == 1 && a_addr != 0) || (g == 2 && b_addr != 0);
      if (m_we) begin
         m_addr = (g == 1) ? a_addr : b_addr;
         m_data = (g == 1) ? a_data : b_data;
      end
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; a_v = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b want 0", a_rdy); end
      if (b_rdy !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b want 0", b_rdy); end
      if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
      if (cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
      rst_n = 1'b1;
      model_reset();
      #1;
      checks++;
      if (a_rdy !== 1'b1) begin errors++; $display("FAIL release_a_ready got %b want 1", a_rdy); end
      tick();
      a_v = 1'b0;
      checks += 3;
      if (we !== 1'b1) begin errors++; $display("FAIL release_we got %b want 1", we); end
      if (wb_addr !== 5'd5) begin errors++; $display("FAIL release_addr got %0d want 5", wb_addr); end
      if (wb_data !== 32'h1234) begin errors++; $display("FAIL release_data got %h want 1234", wb_data); end
   endtask

   task automatic test_contention();
      int exp_cnt [5] = '{1, 2, 3, 0, 1};
      int exp_adr [5] = '{4, 4, 4, 3, 4};
      int exp_a   [5] = '{0, 0, 0, 1, 0};
      a_v = 1'b1; a_addr = 5'd3; a_data = 32'hA3; a_tag = 4'd0;
      b_v = 1'b1; b_addr = 5'd4; b_data = 32'hB4; b_tag = 4'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks += 2;
         if (a_rdy !== exp_a[i][0]) begin errors++; $display("FAIL cont_a_ready[%0d] got %b want %0d", i, a_rdy, exp_a[i]); end
         if (b_rdy !== !exp_a[i][0]) begin errors++; $display("FAIL cont_b_ready[%0d] got %b want %0d", i, b_rdy, 1 - exp_a[i]); end
         tick();
         checks += 3;
         if (int'(cnt) != exp_cnt[i]) begin errors++; $display("FAIL cont_cnt[%0d] got %0d want %0d", i, cnt, exp_cnt[i]); end
         if (int'(wb_addr) != exp_adr[i]) begin errors++; $display("FAIL cont_addr[%0d] got %0d want %0d", i, wb_addr, exp_adr[i]); end
         if (we !== 1'b1) begin errors++; $display("FAIL cont_we[%0d] got %b want 1", i, we); end
      end
      a_v = 1'b0; b_v = 1'b0;
      tick();
   endtask

   task automatic test_same_addr();
      a_v = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA0007; a_tag = 4'd14;
      b_v = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB0007; b_tag = 4'd1;
      #1;
      checks += 2;
      if (a_rdy !== 1'b1) begin errors++; $display("FAIL same_wrap_a_ready got %b want 1", a_rdy); end
      if (b_rdy !== 1'b0) begin errors++; $display("FAIL same_wrap_b_ready got %b want 0", b_rdy); end
      tick();
      checks++;
      if (wb_data !== 32'hAAAA0007) begin errors++; $display("FAIL same_wrap_data got %h want aaaa0007", wb_data); end
      a_tag = 4'd2; b_tag = 4'd2;
      #1;
      checks++;
      if (b_rdy !== 1'b1 || a_rdy !== 1'b0) begin errors++; $display("FAIL same_eq_ready got a=%b b=%b want a=0 b=1", a_rdy, b_rdy); end
      tick();
      checks++;
      if (wb_data !== 32'hBBBB0007) begin errors++; $display("FAIL same_eq_data got %h want bbbb0007", wb_data); end
      a_v = 1'b0; b_v = 1'b0;
   endtask

   task automatic test_x0();
      logic [4:0] prev;
      prev = m_addr;
      b_v = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
      #1;
      checks++;
      if (b_rdy !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", b_rdy); end
      tick();
      b_v = 1'b0;
      checks += 2;
      if (we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", we); end
      if (wb_addr !== prev) begin errors++; $display("FAIL x0_addr got %0d want %0d", wb_addr, prev); end
   endtask

   task automatic test_flush();
      a_v = 1'b1; a_addr = 5'd10; a_data = 32'h10; a_tag = 4'd3;
      b_v = 1'b1; b_addr = 5'd11; b_data = 32'h11; b_tag = 4'd4;
      tick();
      tick();
      checks++;
      if (cnt !== 2'd2) begin errors++; $display("FAIL flush_pre_cnt got %0d want 2", cnt); end
      flush = 1'b1;
      #1;
      checks++;
      if (a_rdy !== 1'b0 || b_rdy !== 1'b0) begin errors++; $display("FAIL flush_ready got a=%b b=%b want 0 0", a_rdy, b_rdy); end
      tick();
      checks += 2;
      if (cnt !== 2'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", cnt); end
      if (we !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", we); end
      flush = 1'b0; a_v = 1'b0; b_v = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      a_v = 1'b1; a_addr = 5'd9; a_data = 32'h99; a_tag = 4'd5;
      tick();
      a_v = 1'b0;
      checks++;
      if (we !== 1'b1) begin errors++; $display("FAIL areset_pre_we got %b want 1", we); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks += 3;
      if (we !== 1'b0) begin errors++; $display("FAIL areset_we got %b want 0", we); end
      if (wb_addr !== 5'd0) begin errors++; $display("FAIL areset_addr got %0d want 0", wb_addr); end
      if (cnt !== 2'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int g;
      bit keep_a, keep_b;
      for (int i = 0; i < 400; i++) begin
         #1;
         g = exp_grant();
         checks += 2;
         if (a_rdy !== (g == 1)) begin errors++; $display("FAIL rnd_a_ready[%0d] got %b want %0d", i, a_rdy, g == 1); end
         if (b_rdy !== (g == 2)) begin errors++; $display("FAIL rnd_b_ready[%0d] got %b want %0d", i, b_rdy, g == 2); end
         keep_a = a_v && g != 1 && !flush;
         keep_b = b_v && g != 2 && !flush;
         tick();
         checks += 4;
         if (we !== m_we) begin errors++; $display("FAIL rnd_we[%0d] got %b want %b", i, we, m_we); end
         if (wb_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %0d want %0d", i, wb_addr, m_addr); end
         if (wb_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, wb_data, m_data); end
         if (int'(cnt) != m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, cnt, m_cnt); end
         if (!keep_a) begin
            a_v = ($urandom % 4) != 0; a_addr = 5'($urandom % 4); a_data = $urandom; a_tag = 4'($urandom);
         end
         if (!keep_b) begin
            b_v = ($urandom % 4) != 0; b_addr = 5'($urandom % 4); b_data = $urandom; b_tag = 4'($urandom);
         end
         flush = ($urandom % 12) == 0;
      end
      flush = 1'b0; a_v = 1'b0; b_v = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_contention();
      test_same_addr();
      test_x0();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
